// File: rtl/elevator_if.sv
// elevator_if: command and status signals between the floor-level controller and the car.
interface elevator_if;
  logic       door_open;
  logic [1:0] updown;
  logic       door;
  logic [2:0] floor;
  modport master (output door_open, updown, input door, floor);
  modport slave (input door_open, updown, output door, floor);
endinterface

// File: rtl/elevator.sv
// elevator: cycle-accurate single car with one floor position counter and one door mechanism.
module elevator #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_TICKS = 10,
  parameter int DOOR_TICKS  = 5,
  parameter int RESET_FLOOR = 0
) (
  input logic       clk,
  input logic       rst,
  elevator_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING} state_t;
  localparam logic [2:0]  TOP       = 3'(NUM_FLOORS - 1);
  localparam logic [2:0]  RST_FLOOR = 3'(RESET_FLOOR);
  localparam logic [15:0] FT_M1     = 16'(FLOOR_TICKS - 1);
  localparam logic [15:0] DT        = 16'(DOOR_TICKS);
  // The edge that accepts a door request already counts as the first opening tick.
  localparam state_t      OPEN_ST   = DOOR_TICKS == 1 ? DOOR_OPEN : DOOR_OPENING;
  localparam logic [15:0] OPEN_T    = DOOR_TICKS == 1 ? 16'd0 : 16'd1;
  state_t      state, state_n;
  logic [15:0] timer, timer_n, close_k;
  logic [2:0]  floor, floor_n;
  logic        door, up_ok, dn_ok, go_up, go_dn;
  assign bus.floor = floor;
  assign bus.door  = door;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      floor <= RST_FLOOR;
      door  <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      floor <= floor_n;
      door  <= state_n == DOOR_OPEN;
    end
  end
  // A moving car with timer 0 carries no partial progress, so it may start either way like IDLE.
  always_comb begin
    state_n = state;
    timer_n = timer;
    floor_n = floor;
    up_ok   = bus.updown == 2'b01 && floor != TOP;
    dn_ok   = bus.updown == 2'b10 && floor != 3'd0;
    go_up   = up_ok && !(state == MOVING_DOWN && timer != '0);
    go_dn   = dn_ok && !(state == MOVING_UP && timer != '0);
    close_k = state == DOOR_OPEN ? DT : timer;
    case (state)
      IDLE, MOVING_UP, MOVING_DOWN: begin
        if (bus.door_open) begin
          state_n = OPEN_ST;
          timer_n = OPEN_T;
        end else if ((go_up || go_dn) && timer == FT_M1) begin
          floor_n = go_up ? floor + 3'd1 : floor - 3'd1;
          timer_n = '0;
          state_n = go_up ? (floor_n != TOP ? MOVING_UP : IDLE) : (floor_n != 3'd0 ? MOVING_DOWN : IDLE);
        end else if (go_up || go_dn) begin
          timer_n = timer + 16'd1;
          state_n = go_up ? MOVING_UP : MOVING_DOWN;
        end else begin
          state_n = IDLE;
          timer_n = '0;
        end
      end
      // Closing takes as many edges as were spent opening (full DOOR_TICKS from fully open).
      DOOR_OPENING, DOOR_OPEN: begin
        if (!bus.door_open) begin
          state_n = close_k <= 16'd1 ? IDLE : DOOR_CLOSING;
          timer_n = close_k <= 16'd1 ? '0 : close_k - 16'd2;
        end else if (state == DOOR_OPENING) begin
          state_n = timer == DT - 16'd1 ? DOOR_OPEN : DOOR_OPENING;
          timer_n = timer == DT - 16'd1 ? '0 : timer + 16'd1;
        end
      end
      DOOR_CLOSING: begin
        if (bus.door_open) begin
          state_n = OPEN_ST;
          timer_n = OPEN_T;
        end else begin
          state_n = timer == '0 ? IDLE : DOOR_CLOSING;
          timer_n = timer == '0 ? '0 : timer - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_elevator.sv
// tb_elevator: directed scoreboard bench for the elevator car with FLOOR_TICKS=4, DOOR_TICKS=5.
module tb_elevator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    logic [2:0] f;
    logic       d;
    string      tag;
  } exp_t;
  exp_t q[$];
  elevator_if bus();
  elevator #(.NUM_FLOORS(8), .FLOOR_TICKS(4), .DOOR_TICKS(5), .RESET_FLOOR(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic d_o, input logic [1:0] ud, input int f, input logic d, input string tag);
    exp_t e;
    bus.door_open = d_o;
    bus.updown = ud;
    q.push_back('{3'(f), d, tag});
    @(posedge clk);
    #1;
    e = q.pop_front();
    n_chk++;
    assert ({bus.floor, bus.door} === {e.f, e.d}) n_pass++;
    else $error("FAIL %s: floor=%0d door=%0b expected floor=%0d door=%0b", e.tag, bus.floor, bus.door, e.f, e.d);
  endtask
  initial begin
    bus.door_open = 1'b0;
    bus.updown = 2'b00;
    repeat (2) tick(0, 2'b00, 0, 0, "reset");
    rst = 1'b0;
    repeat (20) tick(0, 2'b00, 0, 0, "idle_hold");
    for (int i = 1; i <= 12; i++) tick(0, 2'b01, i / 4, 0, "travel_up");
    for (int i = 1; i <= 8; i++) tick(0, 2'b10, 3 - i / 4, 0, "travel_down");
    for (int i = 1; i <= 24; i++) tick(0, 2'b01, 1 + i / 4, 0, "to_top");
    repeat (20) tick(0, 2'b01, 7, 0, "top_limit");
    for (int i = 1; i <= 28; i++) tick(0, 2'b10, 7 - i / 4, 0, "to_bottom");
    repeat (10) tick(0, 2'b10, 0, 0, "bottom_limit");
    repeat (3) tick(0, 2'b01, 0, 0, "partial_up");
    repeat (5) tick(0, 2'b00, 0, 0, "partial_drop");
    repeat (10) tick(0, 2'b11, 0, 0, "cmd_11");
    for (int i = 1; i <= 8; i++) tick(0, 2'b01, i / 4, 0, "to_floor2");
    for (int i = 1; i <= 5; i++) tick(1, 2'b01, 2, i == 5, "door_rise");
    repeat (10) tick(1, 2'b01, 2, 1, "door_hold");
    for (int i = 1; i <= 9; i++) tick(0, 2'b01, i == 9 ? 3 : 2, 0, "door_close_move");
    repeat (2) tick(0, 2'b01, 3, 0, "step_progress");
    for (int i = 1; i <= 5; i++) tick(1, 2'b01, 3, i == 5, "door_abort_step");
    repeat (2) tick(0, 2'b01, 3, 0, "closing");
    for (int i = 1; i <= 5; i++) tick(1, 2'b01, 3, i == 5, "door_reopen");
    repeat (5) tick(0, 2'b00, 3, 0, "close_full");
    repeat (3) tick(1, 2'b00, 3, 0, "opening_partial");
    for (int i = 1; i <= 7; i++) tick(0, 2'b01, i == 7 ? 4 : 3, 0, "opening_abort");
    repeat (2) tick(0, 2'b01, 4, 0, "move_at_4");
    rst = 1'b1;
    tick(0, 2'b01, 0, 0, "rst_moving");
    rst = 1'b0;
    repeat (3) tick(0, 2'b00, 0, 0, "after_rst");
    for (int i = 1; i <= 4; i++) tick(0, 2'b01, i / 4, 0, "to_floor1");
    for (int i = 1; i <= 5; i++) tick(1, 2'b00, 1, i == 5, "door_rise2");
    rst = 1'b1;
    tick(1, 2'b00, 0, 0, "rst_door");
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) tick(0, 2'b01, i / 4, 0, "idle_after_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/elevator.md
Name: elevator

Overview:
Cycle-accurate model of a single elevator car: one car position counter and one door mechanism. It is driven by a floor-level target controller through a door request and a 2-bit up/down command. It reports the current floor and the door state. The controller reacts to door rising/falling edges and floor changes, so the timing of both outputs is part of the contract.

Parameters:
NUM_FLOORS, 8, floors 0..NUM_FLOORS-1; must be ≤8 (floor port is 3 bits).
FLOOR_TICKS, 10, clock cycles of continuous travel command per one-floor move (≥1).
DOOR_TICKS, 5, clock cycles for the door to fully open or fully close (≥1).
RESET_FLOOR, 0, floor after reset.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
door_open  input  1  door request: 1 = open/hold open, 0 = close
updown  input  2  travel command: 00 stop, 01 up, 10 down, 11 treated as stop
door  output  1  1 = door fully open, 0 = not fully open; registered
floor  output  3  current floor, registered, always an integer floor

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (on rising clk with rst=1) overrides everything:
  - floor=RESET_FLOOR, door=0, state=IDLE, timer=0.
  - Reset applies mid-move or mid-door-cycle with no partial floor step.
- States: IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING; one timer counter.
- IDLE (door=0):
  - door_open=1 → DOOR_OPENING, timer=0. door_open has priority over updown.
  - Otherwise, updown=01 and floor<NUM_FLOORS-1 → MOVING_UP, timer=0.
  - Otherwise, updown=10 and floor>0 → MOVING_DOWN, timer=0.
  - Up command at top floor, down command at floor 0, or 00/11 → stay IDLE.
- MOVING_x:
  - Each cycle with a matching command, timer++.
  - When timer reaches FLOOR_TICKS-1: on that edge floor changes by ±1 and timer=0.
  - After the step, continue moving if the command still matches and the limit is not reached; otherwise go to IDLE.
  - Result: exactly one floor per FLOOR_TICKS cycles of uninterrupted command.
  - Command drops to 00/11 or reverses before the step completes → IDLE, floor unchanged, partial progress discarded.
  - door_open=1 while moving → abort the step; floor unchanged; go to DOOR_OPENING, timer=0.
- DOOR_OPENING:
  - door=1 is set on the DOOR_TICKS-th edge after entry; state → DOOR_OPEN.
  - door_open falling before completion → DOOR_CLOSING for the elapsed time already spent (timer reused), then IDLE.
- DOOR_OPEN:
  - door stays 1 while door_open=1; updown is ignored.
  - door_open=0 → DOOR_CLOSING, timer=0.
- DOOR_CLOSING:
  - door=0 is set on the first edge of closing, so the falling edge marks closing start.
  - IDLE after DOOR_TICKS cycles.
  - door_open re-asserted during closing → DOOR_OPENING, timer=0.
  - updown is ignored until IDLE.
- Car never moves unless state is IDLE/MOVING and door=0.
- floor never leaves 0..NUM_FLOORS-1; no wrap-around.
- Each output changes by at most one step per cycle; floor never jumps by more than 1.

Test Plan:
- Reset: rst=1 for 2 cycles with FLOOR_TICKS=4, RESET_FLOOR=0 → floor=0, door=0; idle inputs hold these values for 20 cycles.
- Travel: updown=01 held for 12 cycles → floor 1, 2, 3 at cycles 4, 8, 12 after command. Then updown=10 for 8 cycles → floor returns to 1.
- Limits and abort: from floor 7, updown=01 for 20 cycles → floor stays 7. From floor 0, updown=10 → stays 0. updown=01 for 3 cycles then 00 → floor unchanged. updown=11 for 10 cycles → no motion.
- Door: DOOR_TICKS=5, at floor 2 assert door_open → door=1 exactly 5 cycles later. updown=01 during open → floor stays 2. Deassert door_open → door=0 on next edge; motion is accepted only 5 cycles later.
- Door during travel: updown=01 and door_open=1 asserted 2 cycles into a step → floor unchanged, door rises after 5 cycles. Re-assert door_open during closing → door returns to 1 after 5 cycles.
- Reset mid-operation: rst pulsed while MOVING_UP at floor 4 or with door open → next cycle floor=0, door=0, state IDLE.
